maze_mover: RTL and testbench
=============================

Name: maze_mover

Overview:
- Consumer end of the 4-bit movement interface produced by the button-scan FSM.
- Holds the player position on a ROWS x COLS maze and applies one step per movement-code cycle.
- Detects win (goal reached) and loss (wall hit or edge crossed), and drives the flag back to the FSM so that it latches its terminal state.
- Also exports position and move count to the display logic.

Parameters:
- ROWS, 8, maze rows; row 0 is top.
- COLS, 8, maze columns; column 0 is left.
- START_R, 0, reset row.
- START_C, 0, reset column.
- GOAL_R, 7, goal row.
- GOAL_C, 7, goal column.
- WALLS, maze_pkg::DEFAULT_WALLS, ROWS*COLS bits; bit r*COLS+c = 1 marks cell (r,c) as a wall.
- MAX_MOVES, 64, move budget; used only with MOVE_LIMIT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- movement  input  4  FSM state code: 1 left, 2 right, 3 up, 4 down; all other codes are no-op
- flag  output  1  terminal indication to the FSM (combinational look-ahead, see Behaviour)
- pos_row  output  $clog2(ROWS)  current row
- pos_col  output  $clog2(COLS)  current column
- move_count  output  16  accepted steps, saturating at 16'hFFFF
- game_over  output  1  registered terminal status
- won  output  1  registered; valid when game_over=1

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: pos=(START_R,START_C), move_count=0, game_over=0, won=0, state=PLAY. Reset mid-game returns all outputs to these values on the next edge.
- States (maze_pkg::mover_state_t): PLAY, WIN, LOSE.
- Target cell:
  - left: col-1; right: col+1; up: row-1; down: row+1.
  - Compute with one extra bit so that -1 and ROWS/COLS are detectable. There is no wrap-around.
- Each PLAY cycle with a move code (1-4) classifies the target cell:
  - out_of_bounds: target row<0, row>=ROWS, col<0 or col>=COLS.
  - hit_wall: target in bounds and WALLS bit = 1.
  - reach_goal: target = (GOAL_R,GOAL_C) and not a wall.
- Transitions (PLAY, move code present):
  - out_of_bounds or hit_wall: next state LOSE, position unchanged, move_count+1.
  - reach_goal: next state WIN, position = goal, move_count+1.
  - otherwise: position = target, move_count+1, stay in PLAY.
- PLAY with a non-move code: hold everything.
- WIN and LOSE are absorbing until rst. movement is ignored and position and count are frozen.
- game_over = (state != PLAY); won = (state == WIN).
- flag = game_over OR (state==PLAY AND move code AND (out_of_bounds OR hit_wall OR reach_goal)).
  - This path is combinational, so flag is valid in the same cycle the FSM presents the move code.
  - Zero latency on flag; position and status update at the following edge (latency 1).
- A move code held for N consecutive cycles produces N steps; the FSM presents each code for exactly one cycle.
- If the start cell equals the goal, the block is not in WIN at reset; it reaches WIN only on a move into the goal.

Optional Feature:
- MAZE_MOVE_LIMIT_EN defined:
  - A step that would make move_count reach MAX_MOVES without reaching the goal goes to LOSE.
  - flag look-ahead includes this condition.
  - If the goal is reached on the MAX_MOVES-th step, the result is WIN; goal takes priority over the limit.
- MAZE_MOVE_LIMIT_EN undefined: no budget; only the saturating count remains.

Decomposition:
- maze_pkg:
  - movement code localparams (MV_LEFT=1, MV_RIGHT=2, MV_UP=3, MV_DOWN=4, MV_LOSTWON=9), shared with the FSM.
  - mover_state_t enum.
  - DEFAULT_WALLS constant.
- Sub-module maze_wall_rom(ROWS, COLS, WALLS):
  - Inputs: row, col. Output: wall bit.
  - Combinational lookup; returns 1 for out-of-range indices.

Test Plan:
- Reset: WALLS=0, rst for 2 cycles -> pos=(0,0), move_count=0, flag=0, game_over=0.
- Free moves: WALLS=0, codes right,right,down for one cycle each -> pos=(1,2), move_count=3, flag=0 throughout.
- Edge loss: from (0,0) present up (3) -> flag=1 in the same cycle; next edge game_over=1, won=0, pos=(0,0); further codes leave pos and count unchanged.
- Wall loss: WALLS bit 1 set (cell (0,1)), present right -> flag=1 same cycle; LOSE next edge, pos=(0,0), move_count=1.
- Win: 2x2 maze, WALLS=0, GOAL=(1,1); present right then down -> flag=1 in the down cycle; then won=1, pos=(1,1), move_count=2. Assert rst mid-WIN -> back to (0,0), flag=0.
- Limit (MAZE_MOVE_LIMIT_EN, MAX_MOVES=3, WALLS=0): present right,left,right -> flag=1 on the 3rd move; LOSE with move_count=3. Without the macro -> PLAY continues, pos=(0,1).

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: movement codes shared with the button-scan FSM, mover state type and default maze.
package maze_pkg;
    localparam logic [3:0] MV_LEFT    = 4'd1;
    localparam logic [3:0] MV_RIGHT   = 4'd2;
    localparam logic [3:0] MV_UP      = 4'd3;
    localparam logic [3:0] MV_DOWN    = 4'd4;
    localparam logic [3:0] MV_LOSTWON = 4'd9;
    typedef enum logic [1:0] {PLAY, WIN, LOSE} mover_state_t;
    // 8x8 maze, byte r is row r, bit c is column c; (0,0) and (7,7) are open.
    localparam logic [63:0] DEFAULT_WALLS = 64'h0076_1454_5410_6E00;
endpackage

// File: rtl/maze_wall_rom.sv
// maze_wall_rom: combinational wall lookup; row/col carry one extra bit and out-of-range reads as wall.
module maze_wall_rom #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter logic [ROWS*COLS-1:0] WALLS = '0
) (
    input  logic [$clog2(ROWS):0] row,
    input  logic [$clog2(COLS):0] col,
    output logic                  wall
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int AW = $clog2(ROWS*COLS);
    localparam int IW = AW + 2;
    localparam logic [RW:0] R_LIM = (RW+1)'(ROWS);
    localparam logic [CW:0] C_LIM = (CW+1)'(COLS);
    logic [IW-1:0] idx;
    always_comb begin
        idx  = IW'(row) * IW'(COLS) + IW'(col);
        wall = (row < R_LIM && col < C_LIM) ? WALLS[idx[AW-1:0]] : 1'b1;
    end
endmodule

// File: rtl/maze_mover.sv
// maze_mover: player position, step/win/loss tracking and flag look-ahead for the movement FSM.
// Ports: clk, rst (sync, active-high); movement (FSM code); flag (combinational terminal look-ahead);
// pos_row/pos_col, move_count (saturating), game_over, won (registered status).
// Optional: define MAZE_MOVE_LIMIT_EN to lose when the MAX_MOVES-th step misses the goal.
module maze_mover
    import maze_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int START_R   = 0,
    parameter int START_C   = 0,
    parameter int GOAL_R    = 7,
    parameter int GOAL_C    = 7,
    parameter logic [ROWS*COLS-1:0] WALLS = DEFAULT_WALLS,
    parameter int MAX_MOVES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              movement,
    output logic                    flag,
    output logic [$clog2(ROWS)-1:0] pos_row,
    output logic [$clog2(COLS)-1:0] pos_col,
    output logic [15:0]             move_count,
    output logic                    game_over,
    output logic                    won
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW:0] R1 = (RW+1)'(1);
    localparam logic [CW:0] C1 = (CW+1)'(1);
    localparam logic [RW:0] GR = (RW+1)'(GOAL_R);
    localparam logic [CW:0] GC = (CW+1)'(GOAL_C);
    mover_state_t st;
    logic [RW:0] tr;
    logic [CW:0] tc;
    logic mv, wall, goal, lim, lose;
    logic [15:0] cnt_n;
    // Target uses an extra bit: -1 wraps to all-ones, so it is >= ROWS/COLS and the ROM reports it as a wall.
    maze_wall_rom #(.ROWS(ROWS), .COLS(COLS), .WALLS(WALLS)) u_rom (
        .row(tr),
        .col(tc),
        .wall(wall)
    );
    always_comb begin
        mv    = st == PLAY && (movement == MV_LEFT || movement == MV_RIGHT ||
                               movement == MV_UP   || movement == MV_DOWN);
        tr    = movement == MV_UP   ? {1'b0, pos_row} - R1 :
                movement == MV_DOWN ? {1'b0, pos_row} + R1 : {1'b0, pos_row};
        tc    = movement == MV_LEFT  ? {1'b0, pos_col} - C1 :
                movement == MV_RIGHT ? {1'b0, pos_col} + C1 : {1'b0, pos_col};
        goal  = !wall && tr == GR && tc == GC;
        cnt_n = &move_count ? move_count : move_count + 16'd1;
`ifdef MAZE_MOVE_LIMIT_EN
        lim   = {1'b0, move_count} + 17'd1 == 17'(MAX_MOVES);
`else
        lim   = 1'b0;
`endif
        lose  = wall || (lim && !goal);
    end
    assign game_over = st != PLAY;
    assign won       = st == WIN;
    assign flag      = game_over || (mv && (lose || goal));
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= PLAY;
            pos_row    <= RW'(START_R);
            pos_col    <= CW'(START_C);
            move_count <= '0;
        end else if (mv) begin
            move_count <= cnt_n;
            st         <= goal ? WIN : lose ? LOSE : PLAY;
            if (!lose) begin
                pos_row <= tr[RW-1:0];
                pos_col <= tc[CW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_maze_mover.sv
// tb_maze_mover: scoreboard bench over four maze configurations sharing one clock and reset.
module tb_maze_mover;
    typedef struct {
        string name;
        int    inst;
        bit    cf;
        bit    f;
        int    r;
        int    c;
        int    n;
        bit    g;
        bit    w;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    logic [3:0] mv [4];
    int checks = 0;
    int failures = 0;
    exp_t q[$];

    logic f0, f1, f2, f3, g0, g1, g2, g3, w0, w1, w2, w3;
    logic [2:0] r0, r1, r3, c0, c1, c3;
    logic r2, c2;
    logic [15:0] n0, n1, n2, n3;

    always #5 clk = ~clk;

    maze_mover #(.WALLS(64'h0)) u0 (
        .clk(clk), .rst(rst), .movement(mv[0]), .flag(f0), .pos_row(r0), .pos_col(c0),
        .move_count(n0), .game_over(g0), .won(w0));
    maze_mover #(.WALLS(64'h2)) u1 (
        .clk(clk), .rst(rst), .movement(mv[1]), .flag(f1), .pos_row(r1), .pos_col(c1),
        .move_count(n1), .game_over(g1), .won(w1));
    maze_mover #(.ROWS(2), .COLS(2), .GOAL_R(1), .GOAL_C(1), .WALLS(4'h0)) u2 (
        .clk(clk), .rst(rst), .movement(mv[2]), .flag(f2), .pos_row(r2), .pos_col(c2),
        .move_count(n2), .game_over(g2), .won(w2));
    maze_mover #(.WALLS(64'h0), .MAX_MOVES(3)) u3 (
        .clk(clk), .rst(rst), .movement(mv[3]), .flag(f3), .pos_row(r3), .pos_col(c3),
        .move_count(n3), .game_over(g3), .won(w3));

    function automatic int get(int inst, int fld);
        int v [4][6];
        v[0] = '{int'(f0), int'(r0), int'(c0), int'(n0), int'(g0), int'(w0)};
        v[1] = '{int'(f1), int'(r1), int'(c1), int'(n1), int'(g1), int'(w1)};
        v[2] = '{int'(f2), int'(r2), int'(c2), int'(n2), int'(g2), int'(w2)};
        v[3] = '{int'(f3), int'(r3), int'(c3), int'(n3), int'(g3), int'(w3)};
        return v[inst][fld];
    endfunction

    task automatic chk(string nm, string fld, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s.%s got=%0d want=%0d", nm, fld, act, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge and queue what the monitor must see.
    task automatic cyc(string nm, int inst, logic [3:0] code, logic r, bit cf, bit f,
                       int er, int ec, int en, bit eg, bit ew);
        exp_t e;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < 4; i++) mv[i] = 4'd0;
        mv[inst] = code;
        e = '{nm, inst, cf, f, er, ec, en, eg, ew};
        q.push_back(e);
    endtask

    // Flag is checked just after the drive (same cycle), state just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.cf) chk(e.name, "flag", get(e.inst, 0), int'(e.f));
                @(posedge clk);
                #1;
                chk(e.name, "row", get(e.inst, 1), e.r);
                chk(e.name, "col", get(e.inst, 2), e.c);
                chk(e.name, "count", get(e.inst, 3), e.n);
                chk(e.name, "game_over", get(e.inst, 4), int'(e.g));
                chk(e.name, "won", get(e.inst, 5), int'(e.w));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) mv[i] = 4'd0;
        cyc("rst_a", 0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst0", 0, 4'd0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 4'd0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("rst2", 2, 4'd0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("rst3", 3, 4'd0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("free_r1", 0, 4'd2, 0, 1, 0, 0, 1, 1, 0, 0);
        cyc("free_r2", 0, 4'd2, 0, 1, 0, 0, 2, 2, 0, 0);
        cyc("free_d", 0, 4'd4, 0, 1, 0, 1, 2, 3, 0, 0);
        cyc("idle", 0, 4'd0, 0, 1, 0, 1, 2, 3, 0, 0);
        cyc("noop5", 0, 4'd5, 0, 1, 0, 1, 2, 3, 0, 0);
        cyc("noop9", 0, 4'd9, 0, 1, 0, 1, 2, 3, 0, 0);
        cyc("wall_r", 1, 4'd2, 0, 1, 1, 0, 0, 1, 1, 0);
        cyc("wall_frz", 1, 4'd4, 0, 1, 1, 0, 0, 1, 1, 0);
        cyc("win_r", 2, 4'd2, 0, 1, 0, 0, 1, 1, 0, 0);
        cyc("win_d", 2, 4'd4, 0, 1, 1, 1, 1, 2, 1, 1);
        cyc("win_frz", 2, 4'd1, 0, 1, 1, 1, 1, 2, 1, 1);
        cyc("win_rst", 2, 4'd0, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc("post_rst", 2, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("edge_up", 0, 4'd3, 0, 1, 1, 0, 0, 1, 1, 0);
        cyc("edge_frz", 0, 4'd2, 0, 1, 1, 0, 0, 1, 1, 0);
        cyc("edge_frz2", 0, 4'd4, 0, 1, 1, 0, 0, 1, 1, 0);
        cyc("left_edge", 3, 4'd1, 0, 1, 1, 0, 0, 1, 1, 0);
        cyc("rst_lim", 3, 4'd0, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc("lim_r", 3, 4'd2, 0, 1, 0, 0, 1, 1, 0, 0);
        cyc("lim_l", 3, 4'd1, 0, 1, 0, 0, 0, 2, 0, 0);
`ifdef MAZE_MOVE_LIMIT_EN
        cyc("lim_r3", 3, 4'd2, 0, 1, 1, 0, 0, 3, 1, 0);
`else
        cyc("lim_r3", 3, 4'd2, 0, 1, 0, 0, 1, 3, 0, 0);
`endif
        @(negedge clk);
        for (int i = 0; i < 4; i++) mv[i] = 4'd0;
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
